// File: rtl/branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared constants for the branch predictor:
//   SNT/WNT/WT/ST  - 2-bit saturating counter states (strong/weak, NT/T)
//   CNT_RESET      - counter state every table entry returns to on reset
//   PC_STEP        - byte distance to the sequential next instruction
// ---------------------------------------------------------------------------
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] CNT_RESET = WNT;

    localparam int PC_STEP = 4;

endpackage : bp_pkg

// File: rtl/sat_counter2.sv
// ---------------------------------------------------------------------------
// sat_counter2
// Combinational next-state function of a 2-bit saturating direction counter.
// Ports:
//   state      in  2 : current counter value
//   taken      in  1 : resolved branch outcome
//   next_state out 2 : counter value after training with `taken`
// ---------------------------------------------------------------------------
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] state,
    input  logic       taken,
    output logic [1:0] next_state
);

    always_comb begin
        next_state = state;
        if (taken) begin
            if (state != ST) begin
                next_state = state + 2'd1;
            end
        end else begin
            if (state != SNT) begin
                next_state = state - 2'd1;
            end
        end
    end

endmodule : sat_counter2

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Direct-mapped table of 2-bit direction counters plus a branch target
// buffer. Lookups return a registered prediction one cycle after the
// request; training comes from the resolved branch. Two saturating
// performance counters track accepted lookups and mispredicts.
// Ports:
//   clk, rst                  : clock (rising edge), async active-high reset
//   req_valid, req_pc         : lookup request
//   pred_valid/taken/target   : registered prediction (taken/target hold
//                               while no request is pending)
//   upd_valid, upd_pc,
//   upd_taken, upd_target,
//   upd_mispredict            : training from the branch comparator
//   lookup_cnt, mispredict_cnt: saturating performance counters
// ---------------------------------------------------------------------------
module branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_W    = 10,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [PC_W-1:0]  req_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic             upd_mispredict,
    output logic [CNT_W-1:0] lookup_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int TAG_W = PC_W - IDX_W - 2;

    // Per-entry state, gathered from the generate blocks below so that
    // each entry has exactly one driver.
    logic [1:0]       ctr_q       [ENTRIES];
    logic             btb_valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q       [ENTRIES];
    logic [PC_W-1:0]  target_q    [ENTRIES];

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             lookup_hit;
    logic             lookup_taken;
    logic [PC_W-1:0]  lookup_target;
    logic [1:0]       upd_ctr_cur;
    logic [1:0]       upd_ctr_next;

    // The two low PC bits are byte offsets within an instruction word.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{req_pc[1:0], upd_pc[1:0]};

    assign req_idx = req_pc[IDX_W+1:2];
    assign req_tag = req_pc[PC_W-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[PC_W-1:IDX_W+2];

    // Lookup reads the table state as it stands before this edge, so a
    // same-cycle update to the same entry is not visible (no bypass).
    assign lookup_hit    = btb_valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign lookup_taken  = lookup_hit && ctr_q[req_idx][1];
    assign lookup_target = lookup_taken ? target_q[req_idx]
                                        : req_pc + PC_W'(PC_STEP);

    // Training always starts from the entry's current counter, even when
    // the tag belongs to an aliasing branch.
    assign upd_ctr_cur = ctr_q[upd_idx];

    sat_counter2 u_sat_counter2 (
        .state      (upd_ctr_cur),
        .taken      (upd_taken),
        .next_state (upd_ctr_next)
    );

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic [1:0]       ctr_reg;
            logic             btb_valid_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [PC_W-1:0]  target_reg;
            logic             wr_en;

            assign wr_en = upd_valid && (upd_idx == IDX_W'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ctr_reg       <= CNT_RESET;
                    btb_valid_reg <= 1'b0;
                    tag_reg       <= '0;
                    target_reg    <= '0;
                end else if (wr_en) begin
                    ctr_reg <= upd_ctr_next;
                    // Only taken branches own a target worth remembering.
                    if (upd_taken) begin
                        btb_valid_reg <= 1'b1;
                        tag_reg       <= upd_tag;
                        target_reg    <= upd_target;
                    end
                end
            end

            assign ctr_q[gi]       = ctr_reg;
            assign btb_valid_q[gi] = btb_valid_reg;
            assign tag_q[gi]       = tag_reg;
            assign target_q[gi]    = target_reg;
        end
    endgenerate

    logic             pred_valid_reg;
    logic             pred_taken_reg;
    logic [PC_W-1:0]  pred_target_reg;
    logic [CNT_W-1:0] lookup_cnt_reg;
    logic [CNT_W-1:0] mispredict_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid_reg  <= 1'b0;
            pred_taken_reg  <= 1'b0;
            pred_target_reg <= '0;
        end else begin
            pred_valid_reg <= req_valid;
            if (req_valid) begin
                pred_taken_reg  <= lookup_taken;
                pred_target_reg <= lookup_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_cnt_reg     <= '0;
            mispredict_cnt_reg <= '0;
        end else begin
            if (req_valid && (lookup_cnt_reg != {CNT_W{1'b1}})) begin
                lookup_cnt_reg <= lookup_cnt_reg + CNT_W'(1);
            end
            if (upd_valid && upd_mispredict &&
                (mispredict_cnt_reg != {CNT_W{1'b1}})) begin
                mispredict_cnt_reg <= mispredict_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign pred_valid     = pred_valid_reg;
    assign pred_taken     = pred_taken_reg;
    assign pred_target    = pred_target_reg;
    assign lookup_cnt     = lookup_cnt_reg;
    assign mispredict_cnt = mispredict_cnt_reg;

endmodule : branch_predictor

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
// Directed scenarios followed by a long randomized run, all checked against
// an array-based reference model of the predictor kept in this bench.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int PC_W    = 10;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = 65535;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic [PC_W-1:0]  req_pc = '0;
    logic             pred_valid;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;
    logic             upd_valid = 1'b0;
    logic [PC_W-1:0]  upd_pc = '0;
    logic             upd_taken = 1'b0;
    logic [PC_W-1:0]  upd_target = '0;
    logic             upd_mispredict = 1'b0;
    logic [CNT_W-1:0] lookup_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    branch_predictor #(
        .PC_W    (PC_W),
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_pc         (req_pc),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .lookup_cnt     (lookup_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: counter strength 0..3, BTB valid/tag/target per slot.
    int m_ctr    [ENTRIES];
    bit m_valid  [ENTRIES];
    int m_tag    [ENTRIES];
    int m_target [ENTRIES];
    bit e_valid;
    bit e_taken;
    int e_target;
    int e_lcnt;
    int e_mcnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_ctr[i]    = 1;
            m_valid[i]  = 0;
            m_tag[i]    = 0;
            m_target[i] = 0;
        end
        e_valid  = 0;
        e_taken  = 0;
        e_target = 0;
        e_lcnt   = 0;
        e_mcnt   = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"},  32'(pred_valid),     32'(e_valid));
        check({tag, ".taken"},  32'(pred_taken),     32'(e_taken));
        check({tag, ".target"}, 32'(pred_target),    32'(e_target));
        check({tag, ".lcnt"},   32'(lookup_cnt),     32'(e_lcnt));
        check({tag, ".mcnt"},   32'(mispredict_cnt), 32'(e_mcnt));
    endtask

    // One clock cycle: drive inputs, predict from pre-update model state,
    // train the model, then compare after the edge.
    task automatic cycle(input bit rv, input int rpc, input bit uv, input int upc,
                         input bit ut, input int utgt, input bit um, input string tag);
        int idx;
        int tg;
        @(negedge clk);
        req_valid      = rv;
        req_pc         = PC_W'(rpc);
        upd_valid      = uv;
        upd_pc         = PC_W'(upc);
        upd_taken      = ut;
        upd_target     = PC_W'(utgt);
        upd_mispredict = um;
        e_valid = rv;
        if (rv) begin
            idx = (rpc / 4) % ENTRIES;
            tg  = rpc / (4 * ENTRIES);
            e_taken  = m_valid[idx] && (m_tag[idx] == tg) && (m_ctr[idx] >= 2);
            e_target = e_taken ? m_target[idx] : (rpc + 4) % (1 << PC_W);
            if (e_lcnt < CNT_MAX) e_lcnt++;
        end
        if (uv) begin
            idx = (upc / 4) % ENTRIES;
            if (ut) begin
                if (m_ctr[idx] < 3) m_ctr[idx]++;
                m_valid[idx]  = 1;
                m_tag[idx]    = upc / (4 * ENTRIES);
                m_target[idx] = utgt;
            end else begin
                if (m_ctr[idx] > 0) m_ctr[idx]--;
            end
            if (um && e_mcnt < CNT_MAX) e_mcnt++;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic lookup(input int pc, input string tag);
        cycle(1, pc, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic train(input int pc, input bit t, input int tgt, input string tag);
        cycle(0, 0, 1, pc, t, tgt, 0, tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst            = 1'b1;
        req_valid      = 1'b0;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        do_reset("reset");

        // Cold lookup
        lookup('h040, "cold");
        check("cold_lit.taken", 32'(pred_taken), 32'd0);
        check("cold_lit.target", 32'(pred_target), 32'h044);

        // Training fills the BTB and moves the counter to weak-taken
        train('h040, 1, 'h020, "train1");
        lookup('h040, "trained");
        check("trained_lit.taken", 32'(pred_taken), 32'd1);
        check("trained_lit.target", 32'(pred_target), 32'h020);

        // Saturate high, then come back down to weak-NT
        for (int i = 0; i < 3; i++) train('h040, 1, 'h020, "sat_hi");
        for (int i = 0; i < 2; i++) train('h040, 0, 'h000, "dec");
        lookup('h040, "after_dec");
        check("after_dec_lit.taken", 32'(pred_taken), 32'd0);
        check("after_dec_lit.target", 32'(pred_target), 32'h044);

        // Saturate low: one taken step from strong-NT stays not-taken
        for (int i = 0; i < 4; i++) train('h040, 0, 'h000, "sat_lo");
        train('h040, 1, 'h020, "from_snt");
        lookup('h040, "sat_lo_chk");
        check("sat_lo_lit.taken", 32'(pred_taken), 32'd0);

        // Aliasing: same index, different tag
        train('h040, 1, 'h020, "alias_train");
        train('h040, 1, 'h020, "alias_train");
        lookup('h080, "alias");
        check("alias_lit.taken", 32'(pred_taken), 32'd0);
        check("alias_lit.target", 32'(pred_target), 32'h084);

        // Same-cycle lookup and update on a cold table: read-before-write
        do_reset("reset2");
        cycle(1, 'h040, 1, 'h040, 1, 'h020, 0, "collide");
        check("collide_lit.taken", 32'(pred_taken), 32'd0);
        lookup('h040, "post_collide");
        check("post_collide_lit.taken", 32'(pred_taken), 32'd1);

        // Target wrap
        lookup('h3FC, "wrap");
        check("wrap_lit.target", 32'(pred_target), 32'h000);

        // Mispredict counting, including an ignored flag with no update
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 'h100 + 4 * i, 0, 0, 1, "mp");
        cycle(0, 0, 0, 'h100, 0, 0, 1, "mp_ignored");
        check("mp_lit.mcnt", 32'(mispredict_cnt), 32'd5);

        // Idle cycle: valid drops, taken/target hold
        cycle(0, 'h3FC, 0, 0, 0, 0, 0, "hold");

        // Reset asserted between a request and its response edge
        lookup('h040, "pre_rst");
        @(negedge clk);
        req_valid = 1'b1;
        req_pc    = PC_W'('h040);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        check_outputs("rst_mid");
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b0;
        lookup('h040, "post_rst");

        // Randomized run, long enough to saturate lookup_cnt
        for (int n = 0; n < 70000; n++) begin
            int rpc;
            int upc;
            rpc = ($urandom_range(0, 1) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            upc = ($urandom_range(0, 1) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) rpc = rpc | 'h3C0;
            cycle($urandom_range(0, 99) < 95, rpc,
                  $urandom_range(0, 1) == 1, upc,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 1023)),
                  $urandom_range(0, 3) == 0, "rand");
        end
        check("lcnt_sat_lit", 32'(lookup_cnt), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_branch_predictor

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the fetch stage: it produces the `taken` guess and predicted target that the branch comparator later checks. It holds a direct-mapped table of 2-bit saturating counters with a branch target buffer (BTB). It is trained from the comparator's resolution, using actual outcome, actual target and mispredict flag `c`. Lookups are pipelined with one-cycle latency, and saturating performance counters expose the lookup and mispredict totals.

## Interface
- `PC_W`, 10, PC and target width in bits (matches the comparator's `branch_target`)
- `ENTRIES`, 16, table depth; power of two, ≥ 2
- `IDX_W`, $clog2(ENTRIES), index width (derived)
- `CNT_W`, 16, performance counter width

Ports:
- `clk` in 1: sole clock, rising edge
- `rst` in 1: reset; asynchronous and active-high
- `req_valid` in 1: fetch lookup request
- `req_pc` in PC_W: PC being fetched
- `pred_valid` out 1: prediction valid; registered
- `pred_taken` out 1: predicted direction, fed to the comparator as `taken`
- `pred_target` out PC_W: predicted next PC
- `upd_valid` in 1: a resolved branch is available this cycle
- `upd_pc` in PC_W: PC of the resolved branch
- `upd_taken` in 1: actual outcome (comparator internal `r`)
- `upd_target` in PC_W: actual taken target
- `upd_mispredict` in 1: comparator `c`
- `lookup_cnt` out CNT_W: accepted lookups, saturating
- `mispredict_cnt` out CNT_W: mispredicts, saturating

## Operation
- Index is `pc[IDX_W+1:2]`. Tag is `pc[PC_W-1:IDX_W+2]`. `pc[1:0]` is ignored.
- Each entry holds:
  - a 2-bit counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
  - a BTB valid bit
  - a tag
  - a target of PC_W bits
- Lookup:
  - A hit requires the entry's BTB valid bit set and a matching tag.
  - `pred_taken` = hit AND counter[1].
  - `pred_target` = stored target if `pred_taken`, otherwise `req_pc + 4`. The add is mod 2^PC_W and wraps.
- Update, when `upd_valid` is high:
  - The counter at the update index increments (saturating at 11) if `upd_taken`, otherwise it decrements (saturating at 00).
  - If `upd_taken`, the BTB entry is written: valid=1, tag and target from the update.
  - Not-taken updates leave BTB fields unchanged.
  - On a tag mismatch (alias), the counter is still trained. On a taken update the tag is replaced and the counter is trained from its current value; there is no counter reset on replacement.
- Performance counters:
  - `lookup_cnt` increments on each `req_valid`.
  - `mispredict_cnt` increments when `upd_valid` and `upd_mispredict` are both high. `upd_mispredict` is ignored when `upd_valid` is low.
  - Both hold at all-ones and never wrap.

## Timing
- Lookup latency is 1 cycle. Prediction outputs are registered in the cycle after `req_valid`.
- `pred_valid` is high for exactly one cycle per request.
- When `req_valid` is low, `pred_valid` drops to 0 and `pred_taken`/`pred_target` hold their last values.
- Back-to-back requests are supported, one per cycle, with no stall.
- An update takes effect at the clock edge. The first lookup to see it is one sampled in the following cycle.
- On a same-cycle lookup and update to the same index, the lookup uses pre-update state (read-before-write, no bypass).
- Reset, asynchronous and valid at any time including mid-lookup:
  - all counters go to 01
  - all BTB valid bits go to 0
  - tags and targets go to 0
  - `pred_valid`, `pred_taken`, `pred_target`, `lookup_cnt` and `mispredict_cnt` go to 0
  - a request in flight at reset is dropped and produces no `pred_valid`
- The first rising edge after `rst` deasserts behaves normally.

## Structure
- A shared package `bp_pkg` holds:
  - the counter state constants `SNT`=2'b00, `WNT`=2'b01, `WT`=2'b10, `ST`=2'b11
  - the reset state `CNT_RESET`=`WNT`
  - the instruction step `PC_STEP`=4
- Sub-module `sat_counter2`: combinational next-state for the 2-bit counter, with inputs state and taken and output next state. It is instantiated in the update path.
- Storage is flop arrays, not RAM macros, because of the asynchronous reset of every entry.

## Test plan
- **Reset then cold lookup:** assert `rst`, release, then `req_pc`=0x040 → next cycle `pred_valid`=1, `pred_taken`=0, `pred_target`=0x044.
- **Training:** one update with `upd_pc`=0x040, taken, target 0x020 → counter goes 01→10 and BTB fills. A lookup of 0x040 then gives `pred_taken`=1, `pred_target`=0x020.
- **Saturation:**
  - Three further taken updates → counter holds at 11. Two not-taken updates → 01, and the lookup gives `pred_taken`=0 with target 0x044.
  - Four more not-taken updates → counter holds at 00.
- **Aliasing:** train 0x040 taken, then look up 0x080 (same index, different tag) → `pred_taken`=0, `pred_target`=0x084.
- **Same-cycle collision and wrap:**
  - Lookup of 0x040 in the same cycle as its first taken update → `pred_taken`=0. The next lookup gives `pred_taken`=1.
  - Lookup of 0x3FC on a cold table → `pred_target`=0x000.
- **Counters and reset mid-operation:**
  - 5 updates with `upd_mispredict`=1 plus 1 with `upd_valid`=0 and `upd_mispredict`=1 → `mispredict_cnt`=5.
  - Preload `lookup_cnt` to 0xFFFF and issue a request → count stays 0xFFFF.
  - Assert `rst` between a request and its response edge → no `pred_valid`, and all outputs read 0.
